// File: rtl/lanzones_lsu.sv
// lanzones load/store unit: one RV32I load or store at a time
// toward a word-addressed data port with RRdy/RVld read handshake.
module lanzones_lsu #(
  parameter int RD_TIMEOUT = 64,
  parameter int TO_W       = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        ReqVld,
  output logic        ReqRdy,
  input  logic        ReqWe,
  input  logic [2:0]  ReqFunct3,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RspVld,
  output logic [31:0] RspData,
  output logic        RspErr,
  output logic [31:0] RAddr,
  output logic [31:0] RWData,
  output logic        RWEn,
  output logic [3:0]  RWStrobe,
  output logic        RRdy,
  input  logic        RVld,
  input  logic [31:0] RData
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RSP
  } state_t;

  localparam logic [TO_W-1:0] TO_MAX =
    TO_W'(RD_TIMEOUT - 1);

  state_t          r_state;
  logic            r_we;
  logic [2:0]      r_f3;
  logic [1:0]      r_off;
  logic [TO_W-1:0] r_cnt;

  logic        w_f3_ok;
  logic        w_al_ok;
  logic        w_legal;
  logic [3:0]  w_strb;
  logic [31:0] w_wdata;
  logic [31:0] w_shift;
  logic [31:0] w_ldata;

  assign ReqRdy = (r_state == S_IDLE);

  // Request legality: funct3 set differs for loads and stores,
  // halves need even addresses, words need 4-byte alignment.
  always_comb begin
    w_f3_ok = 1'b0;
    w_al_ok = 1'b1;
    if (ReqWe) begin
      w_f3_ok = (ReqFunct3 == 3'b000) ||
                (ReqFunct3 == 3'b001) ||
                (ReqFunct3 == 3'b010);
    end else begin
      w_f3_ok = (ReqFunct3 == 3'b000) ||
                (ReqFunct3 == 3'b001) ||
                (ReqFunct3 == 3'b010) ||
                (ReqFunct3 == 3'b100) ||
                (ReqFunct3 == 3'b101);
    end
    if (ReqFunct3[1:0] == 2'b01) begin
      w_al_ok = ~ReqAddr[0];
    end else if (ReqFunct3[1:0] == 2'b10) begin
      w_al_ok = (ReqAddr[1:0] == 2'b00);
    end
  end

  assign w_legal = w_f3_ok & w_al_ok;

  // Store lane replication and byte enables from size and offset.
  always_comb begin
    w_strb  = 4'b1111;
    w_wdata = ReqWData;
    unique case (1'b1)
      (ReqFunct3[1:0] == 2'b00): begin
        w_strb  = 4'b0001 << ReqAddr[1:0];
        w_wdata = {4{ReqWData[7:0]}};
      end
      (ReqFunct3[1:0] == 2'b01): begin
        w_strb  = 4'b0011 << ReqAddr[1:0];
        w_wdata = {2{ReqWData[15:0]}};
      end
      default: begin
        w_strb  = 4'b1111;
        w_wdata = ReqWData;
      end
    endcase
  end

  assign w_shift = RData >> {r_off, 3'b000};

  // Load lane extraction with sign or zero extension.
  always_comb begin
    w_ldata = RData;
    unique case (1'b1)
      (r_f3 == 3'b000):
        w_ldata = {{24{w_shift[7]}}, w_shift[7:0]};
      (r_f3 == 3'b100):
        w_ldata = {24'h0, w_shift[7:0]};
      (r_f3 == 3'b001):
        w_ldata = {{16{w_shift[15]}}, w_shift[15:0]};
      (r_f3 == 3'b101):
        w_ldata = {16'h0, w_shift[15:0]};
      default:
        w_ldata = RData;
    endcase
    if (r_we) begin
      w_ldata = '0;
    end
  end

  // Request sequencer with registered memory and response outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_f3     <= 3'b000;
      r_off    <= 2'b00;
      r_cnt    <= '0;
      RspVld   <= 1'b0;
      RspErr   <= 1'b0;
      RspData  <= '0;
      RAddr    <= '0;
      RWData   <= '0;
      RWEn     <= 1'b0;
      RWStrobe <= 4'b0000;
      RRdy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          RspVld   <= 1'b0;
          RspErr   <= 1'b0;
          RWStrobe <= 4'b0000;
          if (ReqVld) begin
            r_we    <= ReqWe;
            r_f3    <= ReqFunct3;
            r_off   <= ReqAddr[1:0];
            r_cnt   <= '0;
            RAddr   <= {2'b00, ReqAddr[31:2]};
            RspData <= '0;
            if (!w_legal) begin
              r_state <= S_RSP;
              RspVld  <= 1'b1;
              RspErr  <= 1'b1;
            end else if (ReqWe) begin
              r_state  <= S_WR;
              RWEn     <= 1'b1;
              RWStrobe <= w_strb;
              RWData   <= w_wdata;
            end else begin
              r_state <= S_RD;
              RRdy    <= 1'b1;
            end
          end
        end
        S_WR: begin
          RWEn    <= 1'b0;
          RspVld  <= 1'b1;
          RspErr  <= 1'b0;
          r_state <= S_RSP;
        end
        S_RD: begin
          if (RVld) begin
            RRdy    <= 1'b0;
            RspData <= w_ldata;
            RspErr  <= 1'b0;
            RspVld  <= 1'b1;
            r_state <= S_RSP;
          end else if (r_cnt == TO_MAX) begin
            RRdy    <= 1'b0;
            RspData <= '0;
            RspErr  <= 1'b1;
            RspVld  <= 1'b1;
            r_state <= S_RSP;
          end else begin
            r_cnt <= r_cnt + TO_W'(1);
          end
        end
        S_RSP: begin
          RspVld   <= 1'b0;
          RspErr   <= 1'b0;
          RWStrobe <= 4'b0000;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lanzones_lsu.sv
// Directed bench for lanzones_lsu with a small byte-lane
// memory model that answers RRdy one cycle later.
module tb_lanzones_lsu;

  logic        clk;
  logic        rstn;
  logic        ReqVld;
  logic        ReqRdy;
  logic        ReqWe;
  logic [2:0]  ReqFunct3;
  logic [31:0] ReqAddr;
  logic [31:0] ReqWData;
  logic        RspVld;
  logic [31:0] RspData;
  logic        RspErr;
  logic [31:0] RAddr;
  logic [31:0] RWData;
  logic        RWEn;
  logic [3:0]  RWStrobe;
  logic        RRdy;
  logic        RVld;
  logic [31:0] RData;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:511];
  logic        m_en;
  logic        m_vld;

  int          lat;
  int          n_wen;
  int          n_rrdy;
  logic [31:0] a1;
  logic [31:0] w_addr;
  logic [3:0]  w_strb;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        r_err;
  logic        rdy_after;
  int          n_rsp;

  lanzones_lsu #(
    .RD_TIMEOUT(8),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .ReqVld(ReqVld),
    .ReqRdy(ReqRdy),
    .ReqWe(ReqWe),
    .ReqFunct3(ReqFunct3),
    .ReqAddr(ReqAddr),
    .ReqWData(ReqWData),
    .RspVld(RspVld),
    .RspData(RspData),
    .RspErr(RspErr),
    .RAddr(RAddr),
    .RWData(RWData),
    .RWEn(RWEn),
    .RWStrobe(RWStrobe),
    .RRdy(RRdy),
    .RVld(RVld),
    .RData(RData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign RVld  = m_vld;
  assign RData = m_vld ? mem[RAddr[8:0]] : 32'h0;

  always @(posedge clk) begin
    m_vld <= m_en && RRdy && !m_vld;
    if (RWEn) begin
      for (int b = 0; b < 4; b++) begin
        if (RWStrobe[b])
          mem[RAddr[8:0]][8*b +: 8] <= RWData[8*b +: 8];
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic we,
                     input logic [2:0] f3,
                     input logic [31:0] a,
                     input logic [31:0] d);
    @(negedge clk);
    ReqVld    = 1'b1;
    ReqWe     = we;
    ReqFunct3 = f3;
    ReqAddr   = a;
    ReqWData  = d;
    @(posedge clk);
    #1;
    ReqVld = 1'b0;
    lat    = 0;
    n_wen  = 0;
    n_rrdy = 0;
    a1     = 32'hx;
    w_addr = 32'hx;
    w_strb = 4'hx;
    w_data = 32'hx;
    r_data = 32'hx;
    r_err  = 1'bx;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (k == 1) a1 = RAddr;
      if (RWEn) begin
        n_wen++;
        w_addr = RAddr;
        w_strb = RWStrobe;
        w_data = RWData;
      end
      if (RRdy) n_rrdy++;
      if (RspVld) begin
        lat    = k;
        r_data = RspData;
        r_err  = RspErr;
      end
    end
    @(negedge clk);
    rdy_after = ReqRdy;
  endtask

  task automatic ld(input string tag,
                    input logic [2:0] f3,
                    input logic [31:0] a,
                    input logic [31:0] exp);
    req(1'b0, f3, a, 32'h0);
    chk({tag, "_data"}, r_data, exp);
    chk({tag, "_err"}, {31'h0, r_err}, 32'h0);
    chk({tag, "_lat"}, lat, 3);
  endtask

  task automatic bad_req(input string tag,
                         input logic we,
                         input logic [2:0] f3,
                         input logic [31:0] a);
    req(we, f3, a, 32'hFFFF_FFFF);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, {31'h0, r_err}, 32'h1);
    chk({tag, "_data"}, r_data, 32'h0);
    chk({tag, "_rrdy"}, n_rrdy, 0);
    chk({tag, "_wen"}, n_wen, 0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h100] = 32'h8899AABB;
    m_en      = 1'b1;
    m_vld     = 1'b0;
    rstn      = 1'b0;
    ReqVld    = 1'b0;
    ReqWe     = 1'b0;
    ReqFunct3 = 3'b000;
    ReqAddr   = 32'h0;
    ReqWData  = 32'h0;
    repeat (3) @(negedge clk);
    ReqVld = 1'b1;
    @(negedge clk);
    chk("rst_rspvld", {31'h0, RspVld}, 32'h0);
    chk("rst_rsperr", {31'h0, RspErr}, 32'h0);
    chk("rst_rwen", {31'h0, RWEn}, 32'h0);
    chk("rst_rrdy", {31'h0, RRdy}, 32'h0);
    chk("rst_strb", {28'h0, RWStrobe}, 32'h0);
    chk("rst_raddr", RAddr, 32'h0);
    chk("rst_rwdata", RWData, 32'h0);
    chk("rst_rspdata", RspData, 32'h0);
    chk("rst_reqrdy", {31'h0, ReqRdy}, 32'h1);
    ReqVld = 1'b0;
    rstn   = 1'b1;

    req(1'b0, 3'b000, 32'h401, 32'h0);
    chk("lb_data", r_data, 32'hFFFFFFAA);
    chk("lb_err", {31'h0, r_err}, 32'h0);
    chk("lb_lat", lat, 3);
    chk("lb_raddr", a1, 32'h100);
    chk("lb_rrdy", n_rrdy, 2);
    chk("lb_wen", n_wen, 0);
    chk("lb_reqrdy", {31'h0, rdy_after}, 32'h1);

    ld("lbu", 3'b100, 32'h403, 32'h00000088);
    ld("lh", 3'b001, 32'h402, 32'hFFFF8899);
    ld("lhu", 3'b101, 32'h400, 32'h0000AABB);
    ld("lw", 3'b010, 32'h400, 32'h8899AABB);

    req(1'b1, 3'b000, 32'h405, 32'h00000012);
    chk("sb_lat", lat, 2);
    chk("sb_wen", n_wen, 1);
    chk("sb_addr", w_addr, 32'h101);
    chk("sb_strb", {28'h0, w_strb}, 32'h2);
    chk("sb_wdata", w_data, 32'h12121212);
    chk("sb_err", {31'h0, r_err}, 32'h0);
    chk("sb_rdata", r_data, 32'h0);
    chk("sb_rrdy", n_rrdy, 0);
    ld("sb_rb", 3'b010, 32'h404, 32'h00001200);

    req(1'b1, 3'b001, 32'h40A, 32'h0000BEEF);
    chk("sh_wen", n_wen, 1);
    chk("sh_strb", {28'h0, w_strb}, 32'hC);
    chk("sh_wdata", w_data, 32'hBEEFBEEF);
    chk("sh_addr", w_addr, 32'h102);
    req(1'b1, 3'b010, 32'h40C, 32'hCAFEF00D);
    chk("sw_wen", n_wen, 1);
    chk("sw_strb", {28'h0, w_strb}, 32'hF);
    chk("sw_wdata", w_data, 32'hCAFEF00D);
    chk("sw_lat", lat, 2);
    ld("sh_rb", 3'b010, 32'h408, 32'hBEEF0000);
    ld("sw_rb", 3'b010, 32'h40C, 32'hCAFEF00D);

    bad_req("lw_mis", 1'b0, 3'b010, 32'h402);
    bad_req("sh_mis", 1'b1, 3'b001, 32'h401);
    bad_req("ld_f3", 1'b0, 3'b011, 32'h400);
    bad_req("st_f3", 1'b1, 3'b100, 32'h400);
    bad_req("lh_mis", 1'b0, 3'b101, 32'h403);

    m_en = 1'b0;
    req(1'b0, 3'b010, 32'h0, 32'h0);
    chk("to_rrdy", n_rrdy, 8);
    chk("to_lat", lat, 9);
    chk("to_err", {31'h0, r_err}, 32'h1);
    chk("to_data", r_data, 32'h0);
    chk("to_reqrdy", {31'h0, rdy_after}, 32'h1);

    @(negedge clk);
    ReqVld    = 1'b1;
    ReqWe     = 1'b0;
    ReqFunct3 = 3'b010;
    ReqAddr   = 32'h400;
    @(posedge clk);
    #1;
    ReqVld = 1'b0;
    @(negedge clk);
    chk("ar_rrdy_pre", {31'h0, RRdy}, 32'h1);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_rrdy", {31'h0, RRdy}, 32'h0);
    chk("ar_reqrdy", {31'h0, ReqRdy}, 32'h1);
    n_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (RspVld) n_rsp++;
    end
    rstn = 1'b1;
    m_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (RspVld) n_rsp++;
    end
    chk("ar_norsp", n_rsp, 0);
    ld("ar_lw", 3'b010, 32'h400, 32'h8899AABB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
